micro_board_judge: RTL and testbench

MICRO_BOARD_JUDGE -- requirements
Module: micro_board_judge

---
 rtl/micro_board_judge_pkg.sv | 42 ++++
 rtl/micro_board_judge_line_checker.sv | 42 ++++
 rtl/micro_board_judge.sv | 153 +++++++++++++++
 tb/tb_micro_board_judge.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/micro_board_judge_pkg.sv
// Shared definitions for the micro-board judge.
//   - cell / macro board-state encodings (EMPTY, P1, P2, DRAW)
//   - FSM state encodings
//   - the 8-line cell index table (0-based cell positions, cell k stored at k-1)
//   - board index range helper
package micro_board_judge_pkg;

   // Cell marks and macro board states share one 2-bit encoding.
   // A cell holding DRAW (11) is treated as empty.
   localparam logic [1:0] EMPTY = 2'b00;
   localparam logic [1:0] P1    = 2'b01;
   localparam logic [1:0] P2    = 2'b10;
   localparam logic [1:0] DRAW  = 2'b11;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE  = 3'd0;
   localparam state_t ST_READ  = 3'd1;
   localparam state_t ST_WAIT  = 3'd2;
   localparam state_t ST_EVAL  = 3'd3;
   localparam state_t ST_WRITE = 3'd4;
   localparam state_t ST_DONE  = 3'd5;

   localparam int NUM_LINES = 8;

   // rows 123,456,789; columns 147,258,369; diagonals 159,357
   localparam logic [3:0] LINE_TAB [NUM_LINES][3] = '{
      '{4'd0, 4'd1, 4'd2},
      '{4'd3, 4'd4, 4'd5},
      '{4'd6, 4'd7, 4'd8},
      '{4'd0, 4'd3, 4'd6},
      '{4'd1, 4'd4, 4'd7},
      '{4'd2, 4'd5, 4'd8},
      '{4'd0, 4'd4, 4'd8},
      '{4'd2, 4'd4, 4'd6}
   };

   function automatic logic idx_valid(input logic [3:0] idx);
      return (idx >= 4'd1) && (idx <= 4'd9);
   endfunction

endpackage

// File: rtl/micro_board_judge_line_checker.sv
// Combinational line evaluation of one 3x3 micro board.
// Ports:
//   cells   in  9x2  cell marks, cells[k-1] holds cell k
//   p1_win  out      some line holds three P1 marks
//   p2_win  out      some line holds three P2 marks
//   full    out      all nine cells hold a P1 or P2 mark
//   blocked out      every line holds at least one P1 and one P2 mark
module micro_board_judge_line_checker
   import micro_board_judge_pkg::*;
(
   input  logic [8:0][1:0] cells,
   output logic            p1_win,
   output logic            p2_win,
   output logic            full,
   output logic            blocked
);

   logic [2:0] m1;
   logic [2:0] m2;

   always_comb begin
      p1_win  = 1'b0;
      p2_win  = 1'b0;
      full    = 1'b1;
      blocked = 1'b1;
      m1      = '0;
      m2      = '0;
      for (int i = 0; i < 9; i++) begin
         if (!((cells[i] == P1) || (cells[i] == P2))) full = 1'b0;
      end
      for (int l = 0; l < NUM_LINES; l++) begin
         for (int k = 0; k < 3; k++) begin
            m1[k] = (cells[LINE_TAB[l][k]] == P1);
            m2[k] = (cells[LINE_TAB[l][k]] == P2);
         end
         if (&m1) p1_win = 1'b1;
         if (&m2) p2_win = 1'b1;
         if (!((|m1) && (|m2))) blocked = 1'b0;
      end
   end

endmodule

// File: rtl/micro_board_judge.sv
// Micro-board judge: reads the nine cells of one micro board from the cell RAM,
// decides its macro state and writes it to the macro board-state RAM.
// Ports:
//   clk, reset         single clock, synchronous active-high reset
//   start, board_idx   one-cycle request to judge micro board 1..9
//   cell_addr          cell-RAM read address {board, cell}
//   cell_data          cell-RAM read data, RD_LAT cycles after cell_addr
//   we, addr, data     macro board-state RAM write port
//   busy, done, result judgement status and last judged state
// Parameter RD_LAT: cell-RAM read latency, 1 or 2.
// Macro EARLY_DRAW_EN: also call a draw once every line holds both players' marks.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for start with a board index in 1..9
// READ     | issuing cell fields 1..9, one per cycle
// WAIT     | RD_LAT cycles for the cell-9 data to land in the shadow
// EVAL     | line check of the shadow, result registered
// WRITE    | macro RAM write when the result is not in-progress
// DONE     | done pulse, result published, busy falls at the next edge
module micro_board_judge
   import micro_board_judge_pkg::*;
#(
   parameter int RD_LAT = 1
)
(
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [3:0] board_idx,
   output logic [7:0] cell_addr,
   input  logic [1:0] cell_data,
   output logic       we,
   output logic [3:0] addr,
   output logic [1:0] data,
   output logic       busy,
   output logic       done,
   output logic [1:0] result
);

   state_t          state;
   logic [3:0]      idx_q;
   logic [3:0]      rd_cnt;
   logic            wait_cnt;
   logic [1:0]      res_q;
   logic [8:0][1:0] shadow;

   // Address pipeline: which cell each returning read belongs to.
   logic [1:0]      pvld;
   logic [3:0]      pidx0;
   logic [3:0]      pidx1;
   logic            cap_vld;
   logic [3:0]      cap_idx;

   logic            p1_win;
   logic            p2_win;
   logic            full;
   logic            blocked;
   logic            draw_ok;
   logic [1:0]      eval_res;

   assign cap_vld = (RD_LAT == 1) ? pvld[0] : pvld[1];
   assign cap_idx = (RD_LAT == 1) ? pidx0   : pidx1;

   micro_board_judge_line_checker u_line_checker (
      .cells   (shadow),
      .p1_win  (p1_win),
      .p2_win  (p2_win),
      .full    (full),
      .blocked (blocked)
   );

   always_comb begin
`ifdef EARLY_DRAW_EN
      draw_ok = full | blocked;
`else
      draw_ok = full;
`endif
      case ({p1_win, p2_win})
         2'b10:   eval_res = P1;
         2'b01:   eval_res = P2;
         2'b11:   eval_res = DRAW;
         default: eval_res = draw_ok ? DRAW : EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         idx_q    <= '0;
         rd_cnt   <= '0;
         wait_cnt <= 1'b0;
         res_q    <= EMPTY;
         shadow   <= '0;
         pvld     <= '0;
         pidx0    <= '0;
         pidx1    <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         result   <= EMPTY;
      end else begin
         done  <= 1'b0;
         pvld  <= {pvld[0], (state == ST_READ)};
         pidx0 <= rd_cnt;
         pidx1 <= pidx0;
         if (cap_vld) shadow[cap_idx - 4'd1] <= cell_data;

         case (state)
            ST_IDLE: begin
               if (start && idx_valid(board_idx)) begin
                  idx_q  <= board_idx;
                  rd_cnt <= 4'd1;
                  busy   <= 1'b1;
                  state  <= ST_READ;
               end
            end
            ST_READ: begin
               if (rd_cnt == 4'd9) begin
                  rd_cnt   <= 4'd0;
                  wait_cnt <= (RD_LAT == 2);
                  state    <= ST_WAIT;
               end else begin
                  rd_cnt <= rd_cnt + 4'd1;
               end
            end
            ST_WAIT: begin
               if (wait_cnt == 1'b0) state <= ST_EVAL;
               else                  wait_cnt <= wait_cnt - 1'b1;
            end
            ST_EVAL: begin
               res_q <= eval_res;
               state <= ST_WRITE;
            end
            ST_WRITE: begin
               done   <= 1'b1;
               result <= res_q;
               state  <= ST_DONE;
            end
            ST_DONE: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign cell_addr = {idx_q, (state == ST_READ) ? rd_cnt : 4'd0};
   assign we        = (state == ST_WRITE) && (res_q != EMPTY);
   assign addr      = idx_q;
   assign data      = res_q;

endmodule

// File: tb/tb_micro_board_judge.sv
// Bench for micro_board_judge: two instances (RD_LAT=1 and RD_LAT=2) share the
// stimulus; each has its own cell-RAM read pipeline and scoreboard queue.
`timescale 1ns/1ps
module tb_micro_board_judge;

   typedef struct {
      logic [3:0] b;
      logic [1:0] r;
      int         s;
   } exp_t;

   typedef int cells_t [9];

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [3:0] board_idx = 4'd0;

   logic [7:0] ca     [2];
   logic [1:0] cd     [2];
   logic       we_w   [2];
   logic [3:0] addr_w [2];
   logic [1:0] data_w [2];
   logic       busy_w [2];
   logic       done_w [2];
   logic [1:0] res_w  [2];

   logic [1:0] mem [256];
   logic [7:0] a1_q  = 8'd0;
   logic [7:0] a2_q  = 8'd0;
   logic [7:0] a2_qq = 8'd0;

   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   exp_t q0[$];
   exp_t q1[$];
   int   wr_cnt [2];
   int   wa [2];
   int   wd [2];
   bit   prev_done [2];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   micro_board_judge #(.RD_LAT(1)) u_dut1 (
      .clk(clk), .reset(reset), .start(start), .board_idx(board_idx),
      .cell_addr(ca[0]), .cell_data(cd[0]), .we(we_w[0]), .addr(addr_w[0]),
      .data(data_w[0]), .busy(busy_w[0]), .done(done_w[0]), .result(res_w[0])
   );

   micro_board_judge #(.RD_LAT(2)) u_dut2 (
      .clk(clk), .reset(reset), .start(start), .board_idx(board_idx),
      .cell_addr(ca[1]), .cell_data(cd[1]), .we(we_w[1]), .addr(addr_w[1]),
      .data(data_w[1]), .busy(busy_w[1]), .done(done_w[1]), .result(res_w[1])
   );

   // Cell RAM model with 1- and 2-cycle read latency.
   always @(posedge clk) begin
      a1_q  <= ca[0];
      a2_q  <= ca[1];
      a2_qq <= a2_q;
   end
   assign cd[0] = mem[a1_q];
   assign cd[1] = mem[a2_qq];

   task automatic chk(input string name, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Reference: judge a board from the game rules with plain counting.
   function automatic logic [1:0] ref_judge(input logic [8:0][1:0] c);
      int own [9];
      int ln [8][3];
      bit w1 = 0;
      bit w2 = 0;
      bit blk = 1;
      int filled = 0;
      int n1;
      int n2;
      for (int i = 0; i < 9; i++) begin
         own[i] = (c[i] == 2'b01) ? 1 : (c[i] == 2'b10) ? 2 : 0;
         if (own[i] != 0) filled++;
      end
      for (int r = 0; r < 3; r++) begin
         ln[r]     = '{3*r, 3*r+1, 3*r+2};
         ln[3 + r] = '{r, r+3, r+6};
      end
      ln[6] = '{0, 4, 8};
      ln[7] = '{2, 4, 6};
      for (int l = 0; l < 8; l++) begin
         n1 = 0;
         n2 = 0;
         for (int j = 0; j < 3; j++) begin
            if (own[ln[l][j]] == 1) n1++;
            if (own[ln[l][j]] == 2) n2++;
         end
         if (n1 == 3) w1 = 1;
         if (n2 == 3) w2 = 1;
         if (n1 == 0 || n2 == 0) blk = 0;
      end
      if (w1 && w2) return 2'b11;
      if (w1) return 2'b01;
      if (w2) return 2'b10;
      if (filled == 9) return 2'b11;
`ifdef EARLY_DRAW_EN
      if (blk) return 2'b11;
`endif
      return 2'b00;
   endfunction

   function automatic logic [8:0][1:0] to_packed(input cells_t v);
      logic [8:0][1:0] c;
      for (int i = 0; i < 9; i++) c[i] = v[i][1:0];
      return c;
   endfunction

   // Monitor: pop the expected judgement whenever an instance pulses done.
   task automatic mon(input int k);
      exp_t e;
      bit   have;
      if (prev_done[k]) chk($sformatf("busy_fall_%0d", k), busy_w[k], 0);
      prev_done[k] = done_w[k];
      if (we_w[k]) begin
         wr_cnt[k]++;
         wa[k] = addr_w[k];
         wd[k] = data_w[k];
      end
      if (done_w[k]) begin
         have = 0;
         if (k == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1; end
         if (k == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1; end
         chk($sformatf("done_expected_%0d", k), have, 1);
         if (have) begin
            chk($sformatf("result_b%0d_%0d", e.b, k), res_w[k], e.r);
            chk($sformatf("busy_at_done_%0d", k), busy_w[k], 1);
            // done pulse ends at the (9+RD_LAT+3)th edge after the one that sampled start
            chk($sformatf("latency_%0d", k), cyc + 1 - e.s, 9 + (k + 1) + 3);
            chk($sformatf("write_count_b%0d_%0d", e.b, k), wr_cnt[k], (e.r != 2'b00) ? 1 : 0);
            if (e.r != 2'b00 && wr_cnt[k] == 1) begin
               chk($sformatf("write_addr_%0d", k), wa[k], e.b);
               chk($sformatf("write_data_%0d", k), wd[k], e.r);
            end
         end
         wr_cnt[k] = 0;
      end
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         for (int k = 0; k < 2; k++) mon(k);
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((busy_w[0] || busy_w[1] || q0.size() != 0 || q1.size() != 0) && n < 80) begin
         tick();
         n++;
      end
      chk("idle_within_budget", int'(n < 80), 1);
   endtask

   task automatic judge(input logic [3:0] b, input logic [8:0][1:0] c, input logic [1:0] r);
      exp_t e;
      wait_idle();
      for (int i = 0; i < 9; i++) mem[{b, 4'(i + 1)}] = c[i];
      start     = 1'b1;
      board_idx = b;
      tick();
      start = 1'b0;
      e.b = b;
      e.r = r;
      e.s = cyc;
      q0.push_back(e);
      q1.push_back(e);
   endtask

   task automatic chk_reset_vals(input string tag);
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("%s_busy_%0d", tag, k), busy_w[k], 0);
         chk($sformatf("%s_done_%0d", tag, k), done_w[k], 0);
         chk($sformatf("%s_we_%0d", tag, k), we_w[k], 0);
         chk($sformatf("%s_addr_%0d", tag, k), addr_w[k], 0);
         chk($sformatf("%s_data_%0d", tag, k), data_w[k], 0);
         chk($sformatf("%s_result_%0d", tag, k), res_w[k], 0);
         chk($sformatf("%s_cell_addr_%0d", tag, k), ca[k], 0);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [8:0][1:0] c;
      logic [3:0]      b;
      int              mode;
      int              v;
      int              s;

      for (int i = 0; i < 256; i++) mem[i] = 2'b00;
      for (int k = 0; k < 2; k++) begin
         wr_cnt[k] = 0; wa[k] = 0; wd[k] = 0; prev_done[k] = 0;
      end

      // reset, with a start sampled in the last reset cycle
      reset = 1'b1;
      tick(); tick();
      start = 1'b1; board_idx = 4'd4;
      tick();
      start = 1'b0;
      chk_reset_vals("reset");
      reset = 1'b0;
      tick(); tick();
      for (int k = 0; k < 2; k++) chk($sformatf("start_in_reset_ignored_%0d", k), busy_w[k], 0);

      // directed boards
      judge(4'd3, to_packed('{1,0,0,0,1,0,0,0,1}), 2'b01);
      judge(4'd7, to_packed('{0,0,2,0,0,2,0,0,2}), 2'b10);
      judge(4'd1, to_packed('{0,0,0,0,0,0,0,0,0}), 2'b00);
      judge(4'd4, to_packed('{1,1,2,2,2,1,1,2,1}), 2'b11);
      judge(4'd6, to_packed('{1,2,0,0,2,0,0,0,1}), 2'b00);
      judge(4'd5, to_packed('{3,3,3,3,3,3,3,3,3}), 2'b00);
      judge(4'd9, to_packed('{1,1,1,3,3,3,2,2,2}), 2'b11);
      judge(4'd8, to_packed('{2,1,1,2,1,3,2,3,3}), 2'b10);

      // invalid indices while idle: nothing starts, latched index unchanged
      wait_idle();
      start = 1'b1; board_idx = 4'd0;
      tick();
      board_idx = 4'd12;
      tick();
      board_idx = 4'd15;
      tick();
      start = 1'b0;
      tick();
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("bad_idx_busy_%0d", k), busy_w[k], 0);
         chk($sformatf("bad_idx_addr_%0d", k), addr_w[k], 8);
      end

      // start while busy is ignored: the first board is written, not board 6
      judge(4'd2, to_packed('{0,2,0,0,2,0,0,2,0}), 2'b10);
      for (int i = 0; i < 9; i++) mem[{4'd6, 4'(i + 1)}] = 2'b01;
      tick(); tick(); tick();
      start = 1'b1; board_idx = 4'd6;
      tick();
      start = 1'b0;
      wait_idle();

      // reset during the fifth READ cycle
      for (int i = 0; i < 9; i++) mem[{4'd8, 4'(i + 1)}] = (i < 3) ? 2'b01 : 2'b00;
      start = 1'b1; board_idx = 4'd8;
      tick();
      start = 1'b0;
      s = cyc;
      tick(); tick(); tick(); tick();
      for (int k = 0; k < 2; k++) chk($sformatf("read5_cell_addr_%0d", k), ca[k], 8'h85);
      chk("read5_cycle", cyc - s, 4);
      reset = 1'b1; start = 1'b1; board_idx = 4'd9;
      tick();
      reset = 1'b0; start = 1'b0;
      for (int k = 0; k < 2; k++) begin
         wr_cnt[k] = 0; prev_done[k] = 0;
      end
      chk_reset_vals("midop");
      repeat (20) tick();
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("after_reset_busy_%0d", k), busy_w[k], 0);
         chk($sformatf("after_reset_no_write_%0d", k), wr_cnt[k], 0);
      end

      // randomized boards against the reference model
      for (int n = 0; n < 40; n++) begin
         b    = 4'($urandom_range(1, 9));
         mode = $urandom_range(0, 2);
         for (int i = 0; i < 9; i++) begin
            case (mode)
               0:       c[i] = 2'($urandom_range(0, 3));
               1:       c[i] = 2'($urandom_range(1, 2));
               default: c[i] = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 2)) : 2'b00;
            endcase
         end
         if ($urandom_range(0, 3) == 0) begin
            wait_idle();
            v = $urandom_range(0, 6);
            start = 1'b1;
            board_idx = (v == 0) ? 4'd0 : 4'(9 + v);
            tick();
            start = 1'b0;
         end
         judge(b, c, ref_judge(c));
      end

      wait_idle();
      tick(); tick();
      chk("queue0_drained", q0.size(), 0);
      chk("queue1_drained", q1.size(), 0);
      for (int k = 0; k < 2; k++) chk($sformatf("stray_write_%0d", k), wr_cnt[k], 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
